// File: rtl/curl_pkg.sv
// curl_pkg: shared curl constants, trit encodings and MWM checker FSM states
package curl_pkg;
  localparam int HASH_LENGTH = 243;
  localparam int STATE_LENGTH = 3 * HASH_LENGTH;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS = 2'b01;
  localparam logic [1:0] TRIT_NEG = 2'b11;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} chk_state_t;
endpackage

// File: rtl/curl_mwm_checker.sv
// curl_mwm_checker: counts trailing zero trits of a curl hash against an MWM; CURL_MWM_ZCNT_EN adds o_zero_cnt
module curl_mwm_checker #(
  parameter int HASH_LENGTH = curl_pkg::HASH_LENGTH,
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_transform_finish,
  input  logic [2*HASH_LENGTH-1:0] i_hash,
  input  logic [CNT_W-1:0]         i_mwm,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic                     o_pass,
`ifdef CURL_MWM_ZCNT_EN
  output logic [CNT_W-1:0]         o_zero_cnt,
`endif
  output logic                     o_overrun
);
  curl_pkg::chk_state_t state, next;
  logic fin_r, armed, pass_r, overrun_r;
  logic [2*HASH_LENGTH-1:0] hash_r;
  logic [CNT_W-1:0] mwm_r, idx, zcnt;
  logic edge_d, zero_t, hit, last;
  // armed masks a finish level that is already high when reset releases
  assign edge_d = armed && i_transform_finish && !fin_r;
  assign zero_t = hash_r[{idx, 1'b0} +: 2] == curl_pkg::TRIT_ZERO;
  assign hit = (zcnt + CNT_W'(1)) == mwm_r;
  assign last = idx == '0;
  always_ff @(posedge i_clk)
    if (i_rst) state <= curl_pkg::IDLE;
    else state <= next;
  always_comb
    case (state)
      curl_pkg::IDLE: next = edge_d ? (i_mwm == '0 ? curl_pkg::DONE : curl_pkg::SCAN) : curl_pkg::IDLE;
      curl_pkg::SCAN: next = (!zero_t || hit || last) ? curl_pkg::DONE : curl_pkg::SCAN;
      curl_pkg::DONE: next = i_ready ? curl_pkg::IDLE : curl_pkg::DONE;
      default: next = curl_pkg::IDLE;
    endcase
  always_ff @(posedge i_clk)
    if (i_rst) begin
      fin_r <= 1'b0;
      armed <= 1'b0;
      overrun_r <= 1'b0;
      pass_r <= 1'b0;
      zcnt <= '0;
      idx <= '0;
      mwm_r <= '0;
      hash_r <= '0;
    end else begin
      fin_r <= i_transform_finish;
      armed <= 1'b1;
      overrun_r <= edge_d && state != curl_pkg::IDLE;
      if (state == curl_pkg::IDLE && edge_d) begin
        hash_r <= i_hash;
        mwm_r <= i_mwm;
        idx <= CNT_W'(HASH_LENGTH - 1);
        zcnt <= '0;
        pass_r <= i_mwm == '0;
      end else if (state == curl_pkg::SCAN) begin
        if (zero_t) begin
          zcnt <= zcnt + CNT_W'(1);
          idx <= last ? idx : idx - CNT_W'(1);
        end
        pass_r <= zero_t && hit;
      end
    end
  always_comb begin
    o_valid = state == curl_pkg::DONE;
    o_pass = o_valid && pass_r;
    o_overrun = overrun_r;
`ifdef CURL_MWM_ZCNT_EN
    o_zero_cnt = o_valid ? zcnt : '0;
`endif
  end
endmodule

// File: tb/tb_curl_mwm_checker.sv
// tb_curl_mwm_checker: directed and randomized checks of curl_mwm_checker against a trit-counting model
module tb_curl_mwm_checker;
  localparam int H = 243;
  logic clk = 1'b0, rst = 1'b1, fin = 1'b0, ready = 1'b0;
  logic [2*H-1:0] hash = '0;
  logic [7:0] mwm = '0;
  logic valid, pass, overrun;
  logic [7:0] zc;
  int vectors = 0, errors = 0;

  curl_mwm_checker #(.HASH_LENGTH(H), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_transform_finish(fin), .i_hash(hash), .i_mwm(mwm),
    .i_ready(ready), .o_valid(valid), .o_pass(pass),
`ifdef CURL_MWM_ZCNT_EN
    .o_zero_cnt(zc),
`endif
    .o_overrun(overrun));

`ifndef CURL_MWM_ZCNT_EN
  assign zc = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Trailing zeros from the top trit, then the outcome and latency they imply.
  task automatic model(input logic [2*H-1:0] h, input int m, output bit p, output int z, output int lat);
    int tz = 0;
    for (int i = H - 1; i >= 0 && h[2*i +: 2] == 2'b00; i--) tz++;
    if (m == 0) begin p = 1; z = 0; lat = 1; end
    else if (tz >= m) begin p = 1; z = m; lat = m + 1; end
    else begin p = 0; z = tz; lat = (tz < H) ? tz + 2 : H + 1; end
  endtask

  function automatic logic [2*H-1:0] rand_hash(input int zeros);
    logic [2*H-1:0] h = '0;
    for (int i = 0; i < H; i++)
      h[2*i +: 2] = (i >= H - zeros) ? 2'b00 : 2'($urandom_range(0, 3));
    if (zeros < H) h[2*(H-1-zeros) +: 2] = 2'b01;
    return h;
  endfunction

  task automatic run(input string tag, input logic [2*H-1:0] h, input int m, input int hold,
                     input int ov_at, input int rst_at);
    bit ep;
    int ez, elat, lat = 0, ov = 0;
    model(h, m, ep, ez, elat);
    @(negedge clk); fin = 1'b0; ready = (hold == 0);
    @(negedge clk); hash = h; mwm = 8'(m); fin = 1'b1;
    do begin
      @(posedge clk); #1; lat++;
      ov += int'(overrun);
      hash = rand_hash($urandom_range(0, H));
      mwm = 8'($urandom);
      fin = (ov_at != 0 && lat >= ov_at);
      rst = (rst_at != 0 && lat == rst_at);
    end while (!valid && lat < 300);
    rst = 1'b0;
    if (rst_at != 0) begin
      check({tag, " aborted valid"}, valid, 0);
      return;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " pass"}, pass, ep);
`ifdef CURL_MWM_ZCNT_EN
    check({tag, " zero_cnt"}, zc, ez);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      ov += int'(overrun);
      check({tag, " held valid"}, valid, 1);
      check({tag, " held pass"}, pass, ep);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " valid drop"}, valid, 0);
    check({tag, " overrun pulses"}, ov, (ov_at != 0) ? 1 : 0);
    ready = 1'b0;
  endtask

  initial begin
    logic [2*H-1:0] h;
    fin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", valid, 0);
    check("reset pass", pass, 0);
    check("reset overrun", overrun, 0);
    check("reset zero_cnt", zc, 0);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("finish high at release valid", valid, 0);
      check("finish high at release overrun", overrun, 0);
    end
    h = rand_hash(10);
    run("mwm9 pass", h, 9, 0, 0, 0);
    run("mwm14 fail", h, 14, 0, 0, 0);
    run("all zero mwm243", '0, 243, 0, 0, 0);
    run("all zero mwm250", '0, 250, 0, 0, 0);
    run("mwm0", rand_hash(0), 0, 0, 0, 0);
    h = '0; h[2*(H-1) +: 2] = 2'b10;
    run("code10 top", h, 1, 0, 0, 0);
    run("ready hold", rand_hash(20), 15, 5, 0, 0);
    run("overrun in scan", rand_hash(30), 9, 0, 3, 0);
    run("reset mid scan", '0, 200, 0, 0, 3);
    run("after reset", rand_hash(12), 12, 1, 0, 0);
    for (int n = 0; n < 30; n++)
      run("random", rand_hash($urandom_range(0, H)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 2)), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/curl_mwm_checker.md
CURL_MWM_CHECKER -- requirements
Module: curl_mwm_checker

Interface
REQ-001 The module SHALL have parameter HASH_LENGTH, default 243, giving the number of trits in the checked hash.
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the width of the MWM and count fields; CNT_W SHALL satisfy 2**CNT_W > HASH_LENGTH.
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 The module SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port i_transform_finish, input, 1 bit: level from the curl core, high while its result is final.
REQ-006 The module SHALL have port i_hash, input, 2*HASH_LENGTH bits: curl result, where trit k occupies bits [2k+1:2k].
REQ-007 The module SHALL have port i_mwm, input, CNT_W bits: required count of trailing zero trits.
REQ-008 The module SHALL have port i_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The module SHALL have port o_valid, output, 1 bit: a result is available.
REQ-010 The module SHALL have port o_pass, output, 1 bit: the hash meets the MWM; it is meaningful only while o_valid is high.
REQ-011 The module SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a finish edge is dropped.
REQ-012 The module SHALL have port o_zero_cnt, output, CNT_W bits, present only with CURL_MWM_ZCNT_EN (see REQ-030).

Function
REQ-013 Trit encoding SHALL be 2'b00 = 0, 2'b01 = +1, 2'b11 = -1; the code 2'b10 SHALL be treated as nonzero.
REQ-014 The block SHALL register i_transform_finish and detect a rising edge: current sample 1, previous sample 0.
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-016 On an edge in IDLE (cycle T), the block SHALL do all of the following in that cycle:
- latch i_hash into hash_r and i_mwm into mwm_r;
- set idx to HASH_LENGTH-1 and zcnt to 0;
- go to SCAN, or go to DONE with pass = 1 if i_mwm == 0.
REQ-017 In SCAN, each cycle SHALL examine trit idx of hash_r, one trit per cycle, scanning from the top (trit HASH_LENGTH-1) downward.
REQ-018 If the examined trit is zero, zcnt SHALL increment and idx SHALL decrement.
REQ-019 If zcnt+1 == mwm_r, the block SHALL go to DONE with pass = 1.
REQ-020 If the examined trit is nonzero, the block SHALL go to DONE with pass = 0, leaving zcnt unchanged.
REQ-021 If idx == 0 is examined as zero and mwm_r > HASH_LENGTH, the block SHALL go to DONE with pass = 0; idx SHALL never wrap.
REQ-022 Latency: with mwm = k (1 ≤ k ≤ HASH_LENGTH) and all examined trits zero, o_valid SHALL rise at T+k+1; with mwm = 0 it SHALL rise at T+1.
REQ-023 In DONE, o_valid SHALL be 1, and o_pass and o_zero_cnt SHALL be held stable until the cycle in which o_valid && i_ready, after which the state SHALL return to IDLE.
REQ-024 When i_ready is already high on entry to DONE, o_valid SHALL last exactly one cycle.
REQ-025 A rising edge detected while in SCAN or DONE SHALL be ignored, pulse o_overrun for one cycle, and leave the result unaffected.
REQ-026 Changes on i_hash or i_mwm after the capture cycle SHALL NOT affect the result.

Reset
REQ-027 While i_rst is high at a clock edge, the block SHALL set:
- state to IDLE;
- o_valid, o_pass and o_overrun to 0;
- zcnt, idx and the edge-detector register to 0.
REQ-028 Reset asserted mid-SCAN or in DONE SHALL abort the operation with no o_valid pulse.
REQ-029 A finish level that is already high when reset is released SHALL NOT be treated as an edge.

Configuration
REQ-030 With CURL_MWM_ZCNT_EN defined, port o_zero_cnt SHALL exist and equal zcnt in DONE (trailing zeros counted, stopping at mwm_r), and SHALL be 0 otherwise.
REQ-031 Without CURL_MWM_ZCNT_EN, port o_zero_cnt and its output logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Shared package curl_pkg SHALL hold:
- HASH_LENGTH (243) and STATE_LENGTH;
- trit encoding constants TRIT_ZERO, TRIT_POS, TRIT_NEG;
- the checker FSM state enum.
REQ-033 The block SHALL be a single module with no sub-module; the edge detector and trit mux SHALL be inline.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Hash with trits 242..233 = 0 and trit 232 = +1, mwm = 9, edge at T -> o_valid at T+10, o_pass = 1, o_zero_cnt = 9.
- Same hash, mwm = 14 -> o_valid at T+12, o_pass = 0, o_zero_cnt = 10.
- All-zero hash, mwm = 243 -> o_pass = 1 at T+244; same hash with mwm = 250 -> o_pass = 0, o_zero_cnt = 243.
- mwm = 0 -> o_valid at T+1, o_pass = 1; trit 242 = 2'b10 with mwm = 1 -> o_pass = 0.
- i_ready held low for 5 cycles in DONE -> o_valid and o_pass stable for all 5; second finish edge during SCAN -> one o_overrun pulse, first result unchanged.
- i_rst for one cycle at T+3 of a scan -> no o_valid; next edge processed normally.
